// File: rtl/aes_round_sched_if.sv
// Request/response handshake and debug status bundle for the AES-128 round scheduler.
// The source/sink side uses the master modport, the core uses the slave modport.
interface aes_round_sched_if;
  logic         start_valid;
  logic         start_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round;
  logic         sbox_owner;

  modport master (
    output start_valid, plaintext, key, out_ready,
    input  start_ready, out_valid, ciphertext, busy, round, sbox_owner
  );

  modport slave (
    input  start_valid, plaintext, key, out_ready,
    output start_ready, out_valid, ciphertext, busy, round, sbox_owner
  );
endinterface

// File: rtl/aes_round_sched.sv
// Iterative AES-128 encryptor with one 16-byte S-box array shared between the
// key schedule (KEY cycle) and the state (DATA cycle) of every round.

module sub_byte (
  input  logic [127:0] block,
  output logic [127:0] sub
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Inverse as x^254 (zero maps to zero), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gmul(x, x);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign sub[127-8*i -: 8] = sbox(block[127-8*i -: 8]);
  end
endmodule

module aes_round_sched (
  input  logic             clk,
  input  logic             rst_n,
  aes_round_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, KEY, DATA, DONE} fsm_t;

  fsm_t         fsm;
  logic [127:0] state;
  logic [127:0] rk;
  logic [3:0]   round;
  logic         start_ready;
  logic         out_valid;
  logic         busy;
  logic         sbox_owner;

  logic [127:0] sub_in;
  logic [127:0] sub_out;
  logic [127:0] rk_next;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [31:0]  t, w0, w1, w2, w3;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Column-major layout: byte 4*c+r sits in row r, column c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return res;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      res[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      res[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      res[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      res[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return res;
  endfunction

  // The S-box array is owned purely by FSM state, so KEY and DATA can never collide.
  always_comb begin
    sub_in = '0;
    case (fsm)
      KEY:     sub_in = {rk[23:0], rk[31:24], 96'h0};
      DATA:    sub_in = state;
      default: sub_in = '0;
    endcase
  end

  sub_byte u_sbox (
    .block (sub_in),
    .sub   (sub_out)
  );

  always_comb begin
    t       = sub_out[127:96] ^ {rcon(round), 24'h0};
    w0      = rk[127:96] ^ t;
    w1      = rk[95:64]  ^ w0;
    w2      = rk[63:32]  ^ w1;
    w3      = rk[31:0]   ^ w2;
    rk_next = {w0, w1, w2, w3};
  end

  assign shifted = shift_rows(sub_out);
  assign mixed   = mix_columns(shifted);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      state       <= '0;
      rk          <= '0;
      round       <= 4'd0;
      start_ready <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      sbox_owner  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.start_valid && start_ready) begin
            state       <= bus.plaintext ^ bus.key;
            rk          <= bus.key;
            round       <= 4'd1;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            fsm         <= KEY;
          end
        end
        KEY: begin
          rk         <= rk_next;
          sbox_owner <= 1'b1;
          fsm        <= DATA;
        end
        DATA: begin
          sbox_owner <= 1'b0;
          if (round == 4'd10) begin
            state     <= shifted ^ rk;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            state <= mixed ^ rk;
            round <= round + 4'd1;
            fsm   <= KEY;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            round       <= 4'd0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            fsm         <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.out_valid   = out_valid;
  assign bus.ciphertext  = state;
  assign bus.busy        = busy;
  assign bus.round       = round;
  assign bus.sbox_owner  = sbox_owner;
endmodule
